// File: rtl/k12a_clock_sequencer_pkg.sv
// Shared types and helpers for the k12a clock sequencer.
package k12a_clock_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_WRITE,
        WRITE,
        PRE_CLOCK,
        HIGH
    } state_t;

    typedef enum logic [1:0] {
        STOP           = 2'b00,
        RUN            = 2'b01,
        STEP           = 2'b10,
        RUN_UNTIL_HALT = 2'b11
    } mode_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/k12a_phase_timer.sv
// Down-counter timing one sequencer phase; done is high on the phase's final tick.
module k12a_phase_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    // Reload at each phase entry with (length - 1), then count down to zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/k12a_clock_sequencer.sv
// Generates cpu_clock, async_write and a stretched core reset for the k12a core
// from one master clock, with stop / free-run / single-step / run-until-halt modes.
module k12a_clock_sequencer
    import k12a_clock_sequencer_pkg::*;
#(
    parameter int unsigned WRITE_DELAY  = 2,
    parameter int unsigned WRITE_WIDTH  = 1,
    parameter int unsigned SETUP_DELAY  = 2,
    parameter int unsigned HIGH_WIDTH   = 5,
    parameter int unsigned RESET_CYCLES = 3,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [1:0]             mode,
    input  logic                   step,
    input  logic                   soft_reset,
    input  logic                   halted,
    output logic                   cpu_clock,
    output logic                   async_write,
    output logic                   cpu_reset_n,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned MAX_PHASE = max2(max2(WRITE_DELAY, WRITE_WIDTH),
                                             max2(SETUP_DELAY, HIGH_WIDTH));
    localparam int unsigned TW  = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);

    if (WRITE_DELAY < 1 || WRITE_WIDTH < 1 || SETUP_DELAY < 1 ||
        HIGH_WIDTH < 1 || RESET_CYCLES < 1) begin : g_param_check
        $error("k12a_clock_sequencer: phase lengths and RESET_CYCLES must be >= 1");
    end

    state_t                 r_state;
    logic                   r_cpu_clock;
    logic                   r_async_write;
    logic                   r_cpu_reset_n;
    logic                   r_busy;
    logic [COUNT_WIDTH-1:0] r_cycle_count;
    logic                   r_rst_active;
    logic [RCW-1:0]         r_rst_cnt;
    logic                   r_soft_pend;
    logic                   r_step_q;
    logic                   r_soft_q;

    state_t                 w_next_state;
    mode_t                  w_mode;
    logic                   w_step_rise;
    logic                   w_soft_rise;
    logic                   w_soft_req;
    logic                   w_run_ok;
    logic                   w_done;
    logic                   w_cycle_end;
    logic                   w_rst_last;
    logic                   w_rst_force;
    logic                   w_seq_start;
    logic                   w_load;
    logic [TW-1:0]          w_load_val;

    assign w_mode      = mode_t'(mode);
    assign w_step_rise = step & ~r_step_q;
    assign w_soft_rise = soft_reset & ~r_soft_q;
    assign w_soft_req  = r_soft_pend | w_soft_rise;
    assign w_run_ok    = (w_mode == RUN) || ((w_mode == RUN_UNTIL_HALT) && !halted);
    assign w_cycle_end = (r_state == HIGH) && w_done;
    assign w_rst_last  = r_rst_active && (r_rst_cnt == RCW'(RESET_CYCLES - 1));
    // The final reset cycle releases the core; whether another cycle follows is up to mode.
    assign w_rst_force = (r_rst_active && !w_rst_last) || w_soft_req;
    assign w_seq_start = w_soft_req && ((r_state == IDLE) || w_cycle_end);
    assign w_load      = (w_next_state != r_state);

    // Next-state decision and the phase length to load on entry to the new state.
    always_comb begin
        w_next_state = r_state;
        w_load_val   = '0;
        case (r_state)
            IDLE: begin
                if (r_rst_active || w_soft_req || w_run_ok ||
                    ((w_mode == STEP) && w_step_rise)) begin
                    w_next_state = PRE_WRITE;
                end
            end
            PRE_WRITE: if (w_done) w_next_state = WRITE;
            WRITE:     if (w_done) w_next_state = PRE_CLOCK;
            PRE_CLOCK: if (w_done) w_next_state = HIGH;
            HIGH: begin
                if (w_done) begin
                    w_next_state = (w_rst_force || w_run_ok) ? PRE_WRITE : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        case (w_next_state)
            PRE_WRITE: w_load_val = TW'(WRITE_DELAY - 1);
            WRITE:     w_load_val = TW'(WRITE_WIDTH - 1);
            PRE_CLOCK: w_load_val = TW'(SETUP_DELAY - 1);
            HIGH:      w_load_val = TW'(HIGH_WIDTH - 1);
            default:   w_load_val = '0;
        endcase
    end

    k12a_phase_timer #(
        .WIDTH (TW)
    ) u_phase_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (w_load),
        .load_val (w_load_val),
        .done     (w_done)
    );

    // State, registered outputs, edge detectors, reset sequencing and cycle counting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cpu_clock   <= 1'b0;
            r_async_write <= 1'b0;
            r_cpu_reset_n <= 1'b0;
            r_busy        <= 1'b0;
            r_cycle_count <= '0;
            r_rst_active  <= 1'b1;
            r_rst_cnt     <= '0;
            r_soft_pend   <= 1'b0;
            r_step_q      <= 1'b0;
            r_soft_q      <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_async_write <= (w_next_state == WRITE);
            r_cpu_clock   <= (w_next_state == HIGH);
            r_busy        <= (w_next_state != IDLE);
            r_step_q      <= step;
            r_soft_q      <= soft_reset;

            if (w_cycle_end && r_cpu_reset_n) begin
                r_cycle_count <= r_cycle_count + COUNT_WIDTH'(1);
            end

            if (w_seq_start) begin
                // New or restarted reset sequence begins at a cycle boundary.
                r_rst_active  <= 1'b1;
                r_rst_cnt     <= '0;
                r_cpu_reset_n <= 1'b0;
                r_soft_pend   <= 1'b0;
            end else begin
                if (w_soft_rise) begin
                    r_soft_pend <= 1'b1;
                end
                if (w_cycle_end && r_rst_active) begin
                    if (w_rst_last) begin
                        r_rst_active  <= 1'b0;
                        r_cpu_reset_n <= 1'b1;
                        r_cycle_count <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RCW'(1);
                    end
                end
            end
        end
    end

    assign cpu_clock   = r_cpu_clock;
    assign async_write = r_async_write;
    assign cpu_reset_n = r_cpu_reset_n;
    assign busy        = r_busy;
    assign cycle_count = r_cycle_count;

endmodule
